cim_seq_reg_file: RTL and testbench

CIM_SEQ_REG_FILE -- requirements
Module: cim_seq_reg_file

---
 rtl/cim_rf_pkg.sv | 25 ++
 rtl/rf_shift_step.sv | 39 +++
 rtl/cim_seq_reg_file.sv | 157 +++++++++++++++
 tb/tb_cim_seq_reg_file.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_rf_pkg.sv
// Shared types and default widths for the sequential register-file ALU.
package cim_rf_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_XOR = 3'd3,
      OP_OR  = 3'd4,
      OP_SLL = 3'd5,
      OP_SRL = 3'd6,
      OP_SRA = 3'd7
   } rf_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_EXEC  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_WB    = 2'd3
   } rf_state_e;

endpackage

// File: rtl/rf_shift_step.sv
// Shift datapath: one bit per enabled cycle, or a full barrel shift when
// CIM_SEQ_RF_BARREL_EN is defined.
module rf_shift_step #(
   parameter int unsigned XLEN = 32
`ifdef CIM_SEQ_RF_BARREL_EN
   ,
   parameter int unsigned SH_W = $clog2(XLEN)
`endif
) (
   input  logic [XLEN-1:0] data_i,
`ifdef CIM_SEQ_RF_BARREL_EN
   input  logic [SH_W-1:0] amt_i,
`endif
   input  logic            left_i,
   input  logic            arith_i,
   input  logic            enable_i,
   output logic [XLEN-1:0] data_o
);

`ifdef CIM_SEQ_RF_BARREL_EN
   always_comb begin
      data_o = data_i;
      if (enable_i) begin
         if (left_i)       data_o = data_i << amt_i;
         else if (arith_i) data_o = XLEN'($signed(data_i) >>> amt_i);
         else              data_o = data_i >> amt_i;
      end
   end
`else
   always_comb begin
      data_o = data_i;
      if (enable_i) begin
         if (left_i) data_o = {data_i[XLEN-2:0], 1'b0};
         else        data_o = {arith_i & data_i[XLEN-1], data_i[XLEN-1:1]};
      end
   end
`endif

endmodule

// File: rtl/cim_seq_reg_file.sv
// Register file with a sequenced ALU (IDLE/EXEC/SHIFT/WB) and an independent
// write port. CIM_SEQ_RF_BARREL_EN selects single-cycle barrel shifts.
module cim_seq_reg_file
   import cim_rf_pkg::*;
#(
   parameter  int unsigned XLEN  = XLEN_DEF,
   parameter  int unsigned NREGS = NREGS_DEF,
   localparam int unsigned IDX_W = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [IDX_W-1:0] rs1_idx,
   input  logic [IDX_W-1:0] rs2_idx,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic             use_imm,
   input  logic [XLEN-1:0]  imm,
   output logic             done_valid,
   output logic [XLEN-1:0]  done_result,
   input  logic             ext_we,
   input  logic [IDX_W-1:0] ext_idx,
   input  logic [XLEN-1:0]  ext_wdata,
   input  logic [IDX_W-1:0] dbg_idx,
   output logic [XLEN-1:0]  dbg_rdata
);

   localparam int unsigned SH_W = $clog2(XLEN);

   logic [XLEN-1:0]  regs_q [NREGS];
   rf_state_e        state_q;
   rf_op_e           op_q;
   logic [XLEN-1:0]  a_q, b_q, buf_q;
   logic [IDX_W-1:0] rd_q;
   logic             ready_q, done_valid_q;
   logic [XLEN-1:0]  done_result_q;
`ifndef CIM_SEQ_RF_BARREL_EN
   logic [SH_W-1:0]  cnt_q;
`endif

   logic [XLEN-1:0] rs1_val, rs2_val, shift_in, shift_out;
   logic [SH_W-1:0] shamt;
   logic            shift_en;

   assign rs1_val = regs_q[rs1_idx];
   assign rs2_val = regs_q[rs2_idx];
   assign shamt   = b_q[SH_W-1:0];

`ifdef CIM_SEQ_RF_BARREL_EN
   assign shift_in = a_q;
   assign shift_en = 1'b1;
`else
   assign shift_in = buf_q;
   assign shift_en = (state_q == ST_SHIFT);
`endif

   rf_shift_step #(
      .XLEN     (XLEN)
   ) u_shift (
      .data_i   (shift_in),
`ifdef CIM_SEQ_RF_BARREL_EN
      .amt_i    (shamt),
`endif
      .left_i   (op_q == OP_SLL),
      .arith_i  (op_q == OP_SRA),
      .enable_i (shift_en),
      .data_o   (shift_out)
   );

   // Sequencer: operand capture, ALU/shift evaluation, writeback pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         op_q          <= OP_ADD;
         a_q           <= '0;
         b_q           <= '0;
         buf_q         <= '0;
         rd_q          <= '0;
         ready_q       <= 1'b1;
         done_valid_q  <= 1'b0;
         done_result_q <= '0;
`ifndef CIM_SEQ_RF_BARREL_EN
         cnt_q         <= '0;
`endif
      end else begin
         done_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  a_q     <= rs1_val;
                  b_q     <= use_imm ? imm : rs2_val;
                  op_q    <= rf_op_e'(req_op);
                  rd_q    <= rd_idx;
                  ready_q <= 1'b0;
                  state_q <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               state_q <= ST_WB;
               case (op_q)
                  OP_ADD:  buf_q <= a_q + b_q;
                  OP_SUB:  buf_q <= a_q + ~b_q + XLEN'(1);
                  OP_AND:  buf_q <= a_q & b_q;
                  OP_XOR:  buf_q <= a_q ^ b_q;
                  OP_OR:   buf_q <= a_q | b_q;
                  default: begin
`ifdef CIM_SEQ_RF_BARREL_EN
                     buf_q <= shift_out;
`else
                     // Zero-amount shifts bypass SHIFT and pass A through.
                     buf_q <= a_q;
                     cnt_q <= shamt;
                     if (shamt != '0) state_q <= ST_SHIFT;
`endif
                  end
               endcase
            end
            ST_SHIFT: begin
`ifndef CIM_SEQ_RF_BARREL_EN
               buf_q <= shift_out;
               cnt_q <= cnt_q - SH_W'(1);
               if (cnt_q == SH_W'(1)) state_q <= ST_WB;
`else
               state_q <= ST_WB;
`endif
            end
            ST_WB: begin
               done_valid_q  <= 1'b1;
               done_result_q <= buf_q;
               ready_q       <= 1'b1;
               state_q       <= ST_IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Array writes; writeback is ordered last so it wins a same-index collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else begin
         if (ext_we && (ext_idx != '0)) regs_q[ext_idx] <= ext_wdata;
         if ((state_q == ST_WB) && (rd_q != '0)) regs_q[rd_q] <= buf_q;
      end
   end

   assign req_ready   = ready_q;
   assign done_valid  = done_valid_q;
   assign done_result = done_result_q;
   assign dbg_rdata   = regs_q[dbg_idx];

endmodule

// File: tb/tb_cim_seq_reg_file.sv
// Self-checking bench for cim_seq_reg_file: directed cases plus random ops
// against an arithmetic reference model of the register array.
module tb_cim_seq_reg_file;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned NREGS = 32;
   localparam int unsigned IDX_W = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic [2:0]       req_op = '0;
   logic [IDX_W-1:0] rs1_idx = '0, rs2_idx = '0, rd_idx = '0;
   logic             use_imm = 1'b0;
   logic [XLEN-1:0]  imm = '0;
   logic             done_valid;
   logic [XLEN-1:0]  done_result;
   logic             ext_we = 1'b0;
   logic [IDX_W-1:0] ext_idx = '0;
   logic [XLEN-1:0]  ext_wdata = '0;
   logic [IDX_W-1:0] dbg_idx = '0;
   logic [XLEN-1:0]  dbg_rdata;

   always #5 clk = ~clk;

   cim_seq_reg_file #(.XLEN(XLEN), .NREGS(NREGS)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
      .use_imm(use_imm), .imm(imm),
      .done_valid(done_valid), .done_result(done_result),
      .ext_we(ext_we), .ext_idx(ext_idx), .ext_wdata(ext_wdata),
      .dbg_idx(dbg_idx), .dbg_rdata(dbg_rdata)
   );

   logic [31:0] model_r [NREGS];
   int total  = 0;
   int passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a ^ b;
         3'd4: return a | b;
         3'd5: return a << sh;
         3'd6: return a >> sh;
         default: return 32'($signed(a) >>> sh);
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
`ifdef CIM_SEQ_RF_BARREL_EN
      return 2 + 0 * int'(op) + 0 * int'(b % 2);
`else
      return (op >= 3'd5) ? 2 + int'(b % 32) : 2;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [4:0] idx, input string tag);
      dbg_idx = idx;
      #1;
      check({tag, " dbg"}, dbg_rdata, model_r[idx]);
   endtask

   task automatic ext_write(input logic [4:0] idx, input logic [31:0] val);
      ext_we = 1'b1; ext_idx = idx; ext_wdata = val;
      step();
      ext_we = 1'b0;
      if (idx != 0) model_r[idx] = val;
   endtask

   task automatic drive(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic ui, input logic [31:0] im);
      req_op = op; rs1_idx = r1; rs2_idx = r2; rd_idx = rd; use_imm = ui; imm = im;
   endtask

   task automatic run_op(input logic [2:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic ui, input logic [31:0] im, input string tag);
      logic [31:0] a, b, exp_v;
      int exp_lat, lat;
      a = model_r[r1];
      b = ui ? im : model_r[r2];
      exp_v = ref_alu(op, a, b);
      exp_lat = ref_lat(op, b);
      check({tag, " ready"}, 32'(req_ready), 32'd1);
      drive(op, r1, r2, rd, ui, im);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      lat = 0;
      while (done_valid !== 1'b1 && lat < 200) begin
         step();
         lat++;
      end
      check({tag, " lat"}, 32'(lat), 32'(exp_lat));
      check({tag, " result"}, done_result, exp_v);
      if (rd != 0) model_r[rd] = exp_v;
      step();
      check({tag, " pulse"}, 32'(done_valid), 32'd0);
      peek(rd, tag);
   endtask

   initial begin
      bit saw;
      for (int i = 0; i < NREGS; i++) model_r[i] = '0;

      // Reset state
      step();
      step();
      rst = 1'b0;
      #1;
      check("rst ready", 32'(req_ready), 32'd1);
      check("rst done_valid", 32'(done_valid), 32'd0);
      check("rst done_result", done_result, 32'd0);
      peek(5'd7, "rst r7");

      // Basic ADD
      ext_write(5'd1, 32'd5);
      ext_write(5'd2, 32'd3);
      run_op(3'd0, 5'd1, 5'd2, 5'd3, 1'b0, 32'd0, "add");
      check("add r3", model_r[3], 32'd8);

      // Arithmetic right shift of the sign bit
      ext_write(5'd1, 32'h8000_0000);
      run_op(3'd7, 5'd1, 5'd0, 5'd4, 1'b1, 32'd4, "sra4");
      check("sra4 r4", model_r[4], 32'hF800_0000);

      // SUB wrap and rd=0 discard
      ext_write(5'd1, 32'd0);
      ext_write(5'd2, 32'd1);
      run_op(3'd1, 5'd1, 5'd2, 5'd5, 1'b0, 32'd0, "sub");
      check("sub r5", model_r[5], 32'hFFFF_FFFF);
      run_op(3'd0, 5'd5, 5'd5, 5'd0, 1'b0, 32'd0, "add rd0");
      ext_write(5'd0, 32'hDEAD_BEEF);
      peek(5'd0, "ext r0");

      // Writeback vs ext write collision
      ext_write(5'd7, 32'd4);
      ext_write(5'd8, 32'd5);
      ext_write(5'd5, 32'd1);
      drive(3'd0, 5'd7, 5'd8, 5'd5, 1'b0, 32'd0);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      ext_we = 1'b1; ext_idx = 5'd5; ext_wdata = 32'd7;
      step();
      ext_we = 1'b0;
      check("coll done", 32'(done_valid), 32'd1);
      model_r[5] = 32'd9;
      peek(5'd5, "coll r5");
      step();
      ext_write(5'd5, 32'd1);
      drive(3'd0, 5'd7, 5'd8, 5'd5, 1'b0, 32'd0);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      step();
      ext_we = 1'b1; ext_idx = 5'd6; ext_wdata = 32'd7;
      step();
      ext_we = 1'b0;
      check("split done", 32'(done_valid), 32'd1);
      model_r[5] = 32'd9;
      model_r[6] = 32'd7;
      peek(5'd5, "split r5");
      peek(5'd6, "split r6");
      step();

      // Zero-amount shifts, including upper immediate bits ignored
      run_op(3'd5, 5'd7, 5'd0, 5'd10, 1'b1, 32'd0, "sll0");
      run_op(3'd6, 5'd8, 5'd0, 5'd11, 1'b1, 32'h20, "srl 0x20");
      check("srl 0x20 r11", model_r[11], 32'd5);

      // Held req_valid: accept only from IDLE after writeback
      ext_write(5'd1, 32'd5);
      ext_write(5'd2, 32'd3);
      drive(3'd0, 5'd1, 5'd2, 5'd9, 1'b0, 32'd0);
      req_valid = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         check($sformatf("held done %0d", k), 32'(done_valid), 32'((k % 3) == 2));
         check($sformatf("held ready %0d", k), 32'(req_ready), 32'((k % 3) == 2));
      end
      req_valid = 1'b0;
      step();
      step();
      model_r[9] = 32'd8;
      peek(5'd9, "held r9");

      // Reset in the middle of a long shift
      ext_write(5'd1, 32'd1);
      drive(3'd5, 5'd1, 5'd0, 5'd12, 1'b1, 32'd20);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      repeat (5) step();
`ifndef CIM_SEQ_RF_BARREL_EN
      check("mid busy", 32'(req_ready), 32'd0);
`endif
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < NREGS; i++) model_r[i] = '0;
      saw = 1'b0;
      for (int k = 0; k < 30; k++) begin
         if (done_valid === 1'b1) saw = 1'b1;
         step();
      end
      check("abort no done", 32'(saw), 32'd0);
      check("abort ready", 32'(req_ready), 32'd1);
      peek(5'd12, "abort r12");
      peek(5'd1, "abort r1");

      // Random traffic
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            ext_write(5'($urandom_range(0, 31)), $urandom);
         end else begin
            run_op(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                   $sformatf("rnd%0d", n));
         end
      end
      for (int i = 0; i < NREGS; i++) peek(5'(i), $sformatf("final r%0d", i));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
